// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the FIR coefficient-load controller.
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_ARM,
    S_FETCH,
    S_LOAD,
    S_RUN
  } seq_state_e;

  function automatic int unsigned tap_count(input int unsigned taps_log2);
    return 32'd1 << taps_log2;
  endfunction

endpackage

// File: rtl/fir_tap_stage_ram.sv
// Coefficient staging RAM: one write port, one registered read port, no reset.
module fir_tap_stage_ram #(
  parameter int unsigned G_ADDR_WIDTH = 4,
  parameter int unsigned G_DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [G_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [G_DATA_WIDTH-1:0] wr_data_i,
  input  logic                    rd_en_i,
  input  logic [G_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [G_DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** G_ADDR_WIDTH;

  logic [G_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [G_DATA_WIDTH-1:0] rd_data_q;

  // Read sees the pre-write contents when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Streams staged coefficients into a FIR, then gates the sample path through it.
module fir_tap_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned G_TAPS_LOG2  = 4,
  parameter int unsigned G_TAP_WIDTH  = 16,
  parameter int unsigned G_DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [G_TAPS_LOG2-1:0]  cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]  cfg_wr_data,
  input  logic                    cfg_wr_valid,
  input  logic                    commit,
  input  logic                    bypass_req,
  output logic                    busy,
  output logic                    taps_loaded,
  output logic                    fir_enable,
  output logic                    fir_bypass,
  output logic [G_TAP_WIDTH-1:0]  fir_tap_din,
  output logic                    fir_tap_din_valid,
  input  logic                    fir_tap_din_ready,
  input  logic [G_DATA_WIDTH-1:0] s_din,
  input  logic                    s_din_valid,
  output logic                    s_din_ready,
  output logic [G_DATA_WIDTH-1:0] fir_din,
  output logic                    fir_din_valid,
  input  logic                    fir_din_ready
);

  localparam int unsigned K = tap_count(G_TAPS_LOG2);
  localparam logic [G_TAPS_LOG2-1:0] LAST_IDX = G_TAPS_LOG2'(K - 1);

  seq_state_e             state_q;
  logic [G_TAPS_LOG2-1:0] idx_q;
  logic                   flush_cnt_q;
  logic                   pending_q;
  logic                   busy_q;
  logic                   loaded_q;
  logic                   enable_q;
  logic                   bypass_q;
  logic                   tap_valid_q;
  logic [G_TAP_WIDTH-1:0] rd_data;
  logic                   run_open;

  fir_tap_stage_ram #(
    .G_ADDR_WIDTH (G_TAPS_LOG2),
    .G_DATA_WIDTH (G_TAP_WIDTH)
  ) u_stage_ram (
    .clk       (clk),
    .wr_en_i   (cfg_wr_valid),
    .wr_addr_i (cfg_wr_addr),
    .wr_data_i (cfg_wr_data),
    .rd_en_i   (state_q == S_FETCH),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      flush_cnt_q <= 1'b0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      loaded_q    <= 1'b0;
      enable_q    <= 1'b0;
      bypass_q    <= 1'b0;
      tap_valid_q <= 1'b0;
    end else begin
      bypass_q <= bypass_req;
      unique case (state_q)
        S_IDLE: begin
          if (commit) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_FLUSH: begin
          idx_q <= '0;
          if (commit) pending_q <= 1'b1;
          if (flush_cnt_q) begin
            state_q  <= S_ARM;
            enable_q <= 1'b1;
          end else begin
            flush_cnt_q <= 1'b1;
          end
        end
        S_ARM: begin
          if (commit) pending_q <= 1'b1;
          if (fir_tap_din_ready) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (commit) pending_q <= 1'b1;
          state_q     <= S_LOAD;
          tap_valid_q <= 1'b1;
        end
        S_LOAD: begin
          if (commit) pending_q <= 1'b1;
          if (fir_tap_din_ready) begin
            tap_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q  <= S_RUN;
              busy_q   <= 1'b0;
              loaded_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + G_TAPS_LOG2'(1);
              state_q <= S_FETCH;
            end
          end
        end
        S_RUN: begin
          // A commit that arrived mid-load is honoured here; the sample path stays shut meanwhile.
          if (commit || pending_q) begin
            pending_q   <= 1'b0;
            state_q     <= S_FLUSH;
            flush_cnt_q <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign run_open = (state_q == S_RUN) && !pending_q;

  assign busy              = busy_q;
  assign taps_loaded       = loaded_q;
  assign fir_enable        = enable_q;
  assign fir_bypass        = bypass_q;
  assign fir_tap_din_valid = tap_valid_q;
  assign fir_tap_din       = tap_valid_q ? rd_data : '0;
  assign fir_din           = s_din;
  assign fir_din_valid     = run_open && s_din_valid;
  assign s_din_ready       = run_open && fir_din_ready;

endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 Parameter G_TAPS_LOG2, default 4, log2 of total tap count K = 2**G_TAPS_LOG2 (equals FIR stages_log2 + depth_log2).
REQ-002 Parameter G_TAP_WIDTH, default 16, coefficient width.
REQ-003 Parameter G_DATA_WIDTH, default 16, sample width.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 cfg_wr_addr  in  G_TAPS_LOG2  staging-RAM write address.
REQ-007 cfg_wr_data  in  G_TAP_WIDTH  coefficient value.
REQ-008 cfg_wr_valid  in  1  staging write strobe, accepted every cycle.
REQ-009 commit  in  1  single-cycle pulse: program staged taps into FIR.
REQ-010 bypass_req  in  1  level: request FIR bypass.
REQ-011 busy  out  1  high outside RUN and IDLE.
REQ-012 taps_loaded  out  1  high once a full K-tap load has completed since reset.
REQ-013 fir_enable / fir_bypass  out  1 each  drive FIR enable and bypass.
REQ-014 fir_tap_din  out  G_TAP_WIDTH; fir_tap_din_valid  out  1; fir_tap_din_ready  in  1  FIR tap stream.
REQ-015 s_din  in  G_DATA_WIDTH; s_din_valid  in  1; s_din_ready  out  1  upstream samples.
REQ-016 fir_din  out  G_DATA_WIDTH; fir_din_valid  out  1; fir_din_ready  in  1  samples to FIR.

Function
REQ-017 States IDLE, FLUSH, ARM, FETCH, LOAD, RUN; reset enters IDLE.
REQ-018 Staging RAM (K x G_TAP_WIDTH) is written on any cycle where cfg_wr_valid=1, in every state.
REQ-019 IDLE: fir_enable=0; commit -> FLUSH.
REQ-020 FLUSH: fir_enable=0 for exactly 2 cycles, tap index cleared to 0, then -> ARM.
REQ-021 ARM: fir_enable=1; wait for fir_tap_din_ready=1 -> FETCH.
REQ-022 FETCH: issue staging read at tap index (1-cycle latency); next cycle -> LOAD with fir_tap_din registered, fir_tap_din_valid=1.
REQ-023 LOAD: hold fir_tap_din/valid stable until fir_tap_din_ready=1; on handshake drop valid, index+1, -> FETCH; on handshake at index K-1 -> RUN, taps_loaded<=1.
REQ-024 Tap throughput is one tap per 2 cycles minimum; taps are sent in address order 0..K-1.
REQ-025 RUN: fir_enable=1; fir_din=s_din, fir_din_valid=s_din_valid, s_din_ready=fir_din_ready (combinational, zero latency).
REQ-026 Outside RUN: s_din_ready=0, fir_din_valid=0; samples are held upstream, never dropped.
REQ-027 fir_bypass is bypass_req registered by one cycle, in all states.
REQ-028 commit in RUN -> FLUSH immediately; an in-flight sample handshake on that same cycle still completes.
REQ-029 commit in FLUSH/ARM/FETCH/LOAD sets a pending flag; on reaching RUN with pending=1, clear it and go to FLUSH next cycle (no samples accepted in that RUN cycle).
REQ-030 cfg_wr_valid to the address being fetched on the same cycle: read returns old data (read-before-write).
REQ-031 Tap index is G_TAPS_LOG2 bits; wrap from K-1 to 0 never occurs during a load.

Reset
REQ-032 Reset values: state IDLE, fir_enable 0, fir_bypass 0, fir_tap_din_valid 0, fir_tap_din 0, busy 0, taps_loaded 0, pending 0, index 0.
REQ-033 Reset mid-load aborts; the FIR sees fir_enable=0 next cycle; staging RAM contents are not cleared.

Structure
REQ-034 State enum and a function computing K from G_TAPS_LOG2 live in shared package fir_ctrl_pkg.
REQ-035 Staging RAM is one sub-module, fir_tap_stage_ram (1W1R, registered read, no reset).

Verification
REQ-036 K=16, write taps 1..16 at addr 0..15, commit, ready always 1 -> taps 1..16 in order, RUN reached 2+1+32 cycles after commit, taps_loaded=1.
REQ-037 ready toggles 1,0 during load -> every tap held stable while ready=0; no duplicate or lost taps.
REQ-038 s_din_valid=1 throughout commit-to-RUN -> s_din_ready=0 until RUN, then first sample 0x1234 forwarded same cycle fir_din_ready=1.
REQ-039 commit again at tap 5 of a load -> load completes, one RUN cycle, second full load of 16 taps follows.
REQ-040 reset asserted at tap 8 -> next cycle fir_enable=0, valid=0, IDLE; new commit reloads all 16 taps from tap 0.
REQ-041 bypass_req=1 in RUN -> fir_bypass=1 one cycle later, state unchanged.
